// File: rtl/sw_debounce.sv
// Per-bit slide-switch conditioner: synchroniser, stability counter, and
// registered debounced level with one-cycle rise/fall/changed pulses.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int LOG2DEBOUNCE = 20,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam logic [LOG2DEBOUNCE-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]        sync_p [SYNC_STAGES];
  logic [WIDTH-1:0]        s;
  logic [LOG2DEBOUNCE-1:0] cnt     [WIDTH];
  logic [LOG2DEBOUNCE-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0]        mism;
  logic [WIDTH-1:0]        flip;

  // Count consecutive mismatched cycles; clears on a match or on reaching the terminal count.
  function automatic logic [LOG2DEBOUNCE-1:0] cnt_step(input logic                    mis,
                                                       input logic [LOG2DEBOUNCE-1:0] c);
    if (!mis || (c == CNT_MAX)) return '0;
    return c + LOG2DEBOUNCE'(1);
  endfunction

  // Synchroniser chain: the only consumer of the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= sw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Stability check against the currently published level
  always_comb begin
    mism = '0;
    flip = '0;
    for (int i = 0; i < WIDTH; i++) cnt_nxt[i] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mism[i]    = s[i] ^ sw_out[i];
      flip[i]    = mism[i] && (cnt[i] == CNT_MAX);
      cnt_nxt[i] = cnt_step(mism[i], cnt[i]);
    end
  end

  // Output stage: level and edge pulses update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sw_out  <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      sw_out  <= sw_out ^ flip;
      sw_rise <= flip & s;
      sw_fall <= flip & ~s;
      changed <= |flip;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=16, LOG2DEBOUNCE=4, SYNC_STAGES=2 (18-clock latency).
module tb_sw_debounce;

  localparam int WIDTH = 16;
  localparam int LAT   = 18;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             changed;

  int vecs = 0;
  int errs = 0;

  sw_debounce #(
    .WIDTH       (WIDTH),
    .LOG2DEBOUNCE(4),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] o,
                           input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f, input logic c);
    check({tag, "_out"},  sw_out,  o);
    check({tag, "_rise"}, sw_rise, r);
    check({tag, "_fall"}, sw_fall, f);
    check({tag, "_chg"},  {{(WIDTH-1){1'b0}}, changed}, {{(WIDTH-1){1'b0}}, c});
  endtask

  // n clocks with the output level fixed and no pulses
  task automatic hold(input string tag, input int n, input logic [WIDTH-1:0] o);
    for (int k = 1; k <= n; k++) begin
      tick();
      check_all(tag, o, '0, '0, 1'b0);
    end
  endtask

  // Output changes o->n on the lat-th clock from now, pulses for exactly that clock
  task automatic expect_flip(input string tag, input int lat,
                             input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] n);
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      if (k == lat)
        check_all({tag, "_edge"}, n, n & ~o, o & ~n, (o != n));
      else if (k < lat)
        check_all({tag, "_pre"}, o, '0, '0, 1'b0);
      else
        check_all({tag, "_post"}, n, '0, '0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = '0;
    #3;
    check_all("rst_async", '0, '0, '0, 1'b0);
    tick();
    tick();
    check_all("rst_hold", '0, '0, '0, 1'b0);
    rst_n = 1'b1;

    // 1: idle after reset
    hold("t1_idle", 200, 16'h0000);

    // 2: single-bit rise
    sw_in = 16'h0001;
    expect_flip("t2_rise", LAT, 16'h0000, 16'h0001);

    // 3: bounce on bit 3, then settle high
    for (int k = 0; k < 20; k++) begin
      sw_in[3] = ~sw_in[3];
      hold("t3_bounce", 5, 16'h0001);
    end
    sw_in[3] = 1'b1;
    expect_flip("t3_settle", LAT, 16'h0001, 16'h0009);

    // 4a: 15 mismatched synced cycles on bit 0 -> no change
    sw_in[0] = 1'b0;
    hold("t4_15_low", 15, 16'h0009);
    sw_in[0] = 1'b1;
    hold("t4_15_back", 20, 16'h0009);

    // 4b: 16 mismatched synced cycles -> one fall, then the restored input rises again
    sw_in[0] = 1'b0;
    hold("t4_16_low", 16, 16'h0009);
    sw_in[0] = 1'b1;
    expect_flip("t4_16_fall", 2, 16'h0009, 16'h0008);
    expect_flip("t4_16_rerise", 15, 16'h0008, 16'h0009);

    // 5: simultaneous multi-bit rise and fall
    sw_in = 16'h00FF;
    expect_flip("t5_settle", LAT, 16'h0009, 16'h00FF);
    sw_in = 16'hFF00;
    expect_flip("t5_swap", LAT, 16'h00FF, 16'hFF00);

    // 6: async reset mid-count, then full-latency restart
    sw_in = 16'h0F0F;
    hold("t6_count", 12, 16'hFF00);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("t6_rst_now", '0, '0, '0, 1'b0);
    tick();
    check_all("t6_rst_low", '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    expect_flip("t6_restart", LAT, 16'h0000, 16'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
